// File: rtl/regfile_write_queue.sv
// regfile_write_queue
//   Write-side front end of the 32 x DATA_W register file. Writeback requests
//   (register index + data) arrive over a valid/ready handshake and are held
//   in a small FIFO. The FIFO drains one entry per cycle into a registered
//   one-hot WriteEnable strobe and a registered WriteData bus. A pending-write
//   query lets issue logic stall on registers whose writes are still in flight.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous active-low reset
//   in_valid      writeback request present
//   in_ready      queue has room (depends on registered count only)
//   in_addr       destination register index
//   in_data       data to write
//   wb_hold       suppress draining this cycle
//   WriteEnable   registered one-hot write strobe (bit 31 never set)
//   WriteData     registered write data (holds when nothing drains)
//   query_addr    register index to check
//   query_pending combinational: write to query_addr queued or strobed
//   count         number of queued entries, 0..DEPTH
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     wb_hold,
  output logic [31:0]              WriteEnable,
  output logic [DATA_W-1:0]        WriteData,
  input  logic [4:0]               query_addr,
  output logic                     query_pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [4:0]        addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count_q;
  logic              push;
  logic              pop;
  logic [4:0]        head_addr;
  logic [PTR_W-1:0]  offs;
  logic              hit;

  assign in_ready  = (count_q != FULL_CNT);
  assign push      = in_valid && in_ready;
  assign pop       = (count_q != '0) && !wb_hold;
  assign head_addr = addr_mem[rd_ptr];
  assign count     = count_q;

  // Storage needs no reset: only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Register 31 is hardwired zero: its writes are consumed but never strobed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      WriteEnable <= '0;
      WriteData   <= '0;
    end else if (pop) begin
      WriteEnable <= (head_addr == 5'd31) ? 32'd0 : (32'd1 << head_addr);
      WriteData   <= data_mem[rd_ptr];
    end else begin
      WriteEnable <= '0;
    end
  end

  // Slot i holds a live entry when its distance from the head is below count.
  always_comb begin
    hit  = 1'b0;
    offs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PTR_W'(i) - rd_ptr;
      if (({1'b0, offs} < count_q) && (addr_mem[PTR_W'(i)] == query_addr))
        hit = 1'b1;
    end
    query_pending = (query_addr != 5'd31) && (hit || WriteEnable[query_addr]);
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
module tb_regfile_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        in_addr = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              wb_hold = 1'b0;
  logic [31:0]       WriteEnable;
  logic [DATA_W-1:0] WriteData;
  logic [4:0]        query_addr = '0;
  logic              query_pending;
  logic [$clog2(DEPTH):0] count;

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold),
    .WriteEnable(WriteEnable), .WriteData(WriteData),
    .query_addr(query_addr), .query_pending(query_pending), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes plus the strobe/data
  // that the last drain produced.
  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } ent_t;

  ent_t        m_q[$];
  ent_t        m_e;
  logic [31:0] m_we = '0;
  logic [63:0] m_wd = '0;
  bit          m_push;
  bit          m_pop;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_we = '0;
      m_wd = '0;
    end else begin
      m_push = in_valid && (m_q.size() < DEPTH);
      m_pop  = (m_q.size() > 0) && !wb_hold;
      if (m_pop) begin
        m_e  = m_q.pop_front();
        m_we = (m_e.addr == 5'd31) ? 32'd0 : (32'd1 << m_e.addr);
        m_wd = m_e.data;
      end else begin
        m_we = '0;
      end
      if (m_push) begin
        m_e.addr = in_addr;
        m_e.data = in_data;
        m_q.push_back(m_e);
      end
    end
  end

  function automatic bit model_pending(input logic [4:0] qa);
    bit p = 1'b0;
    if (qa == 5'd31) return 1'b0;
    foreach (m_q[k]) if (m_q[k].addr == qa) p = 1'b1;
    return p || m_we[qa];
  endfunction

  // Compare process: inputs change just after the rising edge, so the
  // falling edge sees both stable inputs and settled outputs.
  always @(negedge clk) begin
    chk("count", 64'(count), 64'(m_q.size()));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() != DEPTH));
    chk("WriteEnable", 64'(WriteEnable), 64'(m_we));
    chk("WriteData", WriteData, m_wd);
    chk("query_pending", 64'(query_pending), 64'(model_pending(query_addr)));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [4:0] a, input logic [63:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_we", 64'(WriteEnable), 64'd0);
    chk("rst_wd", WriteData, 64'd0);
    reset = 1'b1;
    tick();
    chk("rst_ready", 64'(in_ready), 64'd1);

    // Single write to register 5
    push_req(5'd5, 64'hDEAD_BEEF);
    chk("single_count1", 64'(count), 64'd1);
    chk("single_we_early", 64'(WriteEnable), 64'd0);
    tick();
    chk("single_we", 64'(WriteEnable), 64'h0000_0020);
    chk("single_wd", WriteData, 64'hDEAD_BEEF);
    chk("single_count0", 64'(count), 64'd0);
    tick();
    chk("single_we_off", 64'(WriteEnable), 64'd0);

    // Register 31 is consumed but never strobed
    push_req(5'd31, 64'hFFFF);
    chk("r31_count1", 64'(count), 64'd1);
    query_addr = 5'd31;
    #1;
    chk("r31_pending", 64'(query_pending), 64'd0);
    tick();
    chk("r31_count0", 64'(count), 64'd0);
    chk("r31_we", 64'(WriteEnable), 64'd0);
    tick();
    chk("r31_we2", 64'(WriteEnable), 64'd0);

    // Fill under hold, then back-pressure
    wb_hold = 1'b1;
    for (int a = 1; a <= 4; a++) push_req(5'(a), 64'(a * 16'h1111));
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_ready", 64'(in_ready), 64'd0);
    push_req(5'd9, 64'h9999);
    chk("fill_count_after", 64'(count), 64'd4);
    query_addr = 5'd9;
    #1;
    chk("fill_9_rejected", 64'(query_pending), 64'd0);
    wb_hold = 1'b0;
    tick();
    chk("drain_we0", 64'(WriteEnable), 64'h2);
    tick();
    chk("drain_we1", 64'(WriteEnable), 64'h4);
    tick();
    chk("drain_we2", 64'(WriteEnable), 64'h8);
    tick();
    chk("drain_we3", 64'(WriteEnable), 64'h10);
    tick();
    chk("drain_done", 64'(WriteEnable), 64'h0);

    // Full queue with drain re-enabled: no push on the full cycle
    wb_hold = 1'b1;
    for (int a = 10; a <= 13; a++) push_req(5'(a), 64'(a));
    wb_hold  = 1'b0;
    in_valid = 1'b1;
    in_addr  = 5'd14;
    in_data  = 64'h14;
    #1;
    chk("full_ready", 64'(in_ready), 64'd0);
    tick();
    chk("full_count_pop", 64'(count), 64'd3);
    chk("full_we", 64'(WriteEnable), 64'h0000_0400);
    tick();
    chk("full_count_pushpop", 64'(count), 64'd3);
    in_valid = 1'b0;
    repeat (5) tick();
    chk("full_drained", 64'(count), 64'd0);

    // Pending query through the strobe cycle
    wb_hold = 1'b1;
    push_req(5'd7, 64'h77);
    query_addr = 5'd7;
    #1;
    chk("pend_7", 64'(query_pending), 64'd1);
    query_addr = 5'd8;
    #1;
    chk("pend_8", 64'(query_pending), 64'd0);
    query_addr = 5'd7;
    wb_hold = 1'b0;
    tick();
    chk("pend_7_we", 64'(WriteEnable), 64'h80);
    chk("pend_7_strobe", 64'(query_pending), 64'd1);
    tick();
    chk("pend_7_done", 64'(query_pending), 64'd0);

    // Async reset mid-drain
    wb_hold = 1'b1;
    push_req(5'd2, 64'h22);
    push_req(5'd3, 64'h33);
    push_req(5'd4, 64'h44);
    wb_hold = 1'b0;
    tick();
    chk("mid_we_before", 64'(WriteEnable), 64'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_we_reset", 64'(WriteEnable), 64'd0);
    chk("mid_count_reset", 64'(count), 64'd0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_no_stale", 64'(WriteEnable), 64'd0);
    end

    // Randomized traffic against the model, many pointer wraps
    for (int k = 0; k < 3000; k++) begin
      in_valid   = ($urandom_range(0, 99) < 65);
      in_addr    = ($urandom_range(0, 3) == 0) ? 5'(27 + $urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      in_data    = {$urandom(), $urandom()};
      wb_hold    = ($urandom_range(0, 99) < 30);
      query_addr = 5'($urandom_range(0, 31));
      tick();
    end
    in_valid = 1'b0;
    wb_hold  = 1'b0;
    repeat (DEPTH + 2) tick();
    chk("final_empty", 64'(count), 64'd0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Write-side front end of the 32 x 64-bit register file.
- Accepts writeback requests (register index plus data) from the pipeline over a valid/ready handshake and buffers them in a small FIFO.
- Drains one request per cycle into the register array as a registered one-hot WriteEnable vector and a WriteData bus.
- Exposes a pending-write query so the issue logic can stall on registers with writes still in flight.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
DATA_W, 64, data width per register

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  writeback request present
in_ready  output  1  queue can accept a request this cycle
in_addr  input  5  destination register index, 0..31
in_data  input  DATA_W  data to write
wb_hold  input  1  when 1, the queue must not drain this cycle
WriteEnable  output  32  one-hot write strobe to the register array (registered)
WriteData  output  DATA_W  write data to the register array (registered)
query_addr  input  5  register index to check for pending writes
query_pending  output  1  combinational; 1 if a write to query_addr is still in flight
count  output  $clog2(DEPTH)+1  number of queued entries

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; count=0; read and write pointers 0.
  - WriteEnable=0, WriteData=0.
  - in_ready=1 once reset is released.
  - Reset mid-drain discards all queued entries; no WriteEnable bit may glitch high.
- Push: occurs when in_valid && in_ready at the edge. Entry {in_addr, in_data} goes to the write pointer; the pointer wraps modulo DEPTH.
- in_ready = (count != DEPTH), combinational from registered count only. It does not depend on in_valid, and it does not anticipate a same-cycle pop.
- Pop condition: count != 0 && !wb_hold at the edge. On a pop:
  - The head entry is removed and the read pointer wraps modulo DEPTH.
  - WriteEnable <= (head.addr == 31) ? 32'b0 : (1 << head.addr).
  - WriteData <= head.data.
  - Writes to register 31 are consumed and silently dropped. Register 31 is hardwired zero and must never be strobed.
- No pop (empty or wb_hold=1): WriteEnable <= 0 and WriteData holds its previous value.
- Simultaneous push and pop: both occur and count is unchanged. This includes count==DEPTH-1 and the case where the pop empties the old head.
- Full with wb_hold=1: in_ready=0 and in_valid is ignored. No entry is overwritten.
- Order: strictly FIFO. Two writes to the same register land in arrival order, so the last one wins in the array.
- Latency:
  - A request pushed at edge N into an empty queue, with wb_hold=0, is popped at edge N+1.
  - WriteEnable is high for the cycle after edge N+1.
  - The array captures the write at edge N+2.
- Throughput: one write per cycle sustained.
- query_pending is 1 if either of these holds, else 0:
  - any valid FIFO entry has addr == query_addr, or
  - WriteEnable[query_addr] == 1 (write issued but not yet captured).
  - query_pending is always 0 when query_addr == 31.
- count arithmetic is unsigned, range 0..DEPTH. There is no underflow or overflow path: pushes are gated by in_ready and pops by count != 0.
- No bypass from input to WriteEnable in the same cycle.

Test Plan:
- Reset then single write: push addr=5, data=64'hDEAD_BEEF at edge 1 -> WriteEnable=32'h0000_0020 and WriteData=64'hDEAD_BEEF during cycle after edge 2; WriteEnable=0 next cycle; count back to 0.
- Register 31 drop: push addr=31, data=64'hFFFF -> entry is consumed (count 1->0) but WriteEnable stays 0 throughout; query_pending=0 for query_addr=31.
- Fill and backpressure: wb_hold=1, push addrs 1,2,3,4 -> count=4, in_ready=0; a fifth request with addr=9 is not accepted. Release wb_hold -> WriteEnable is 0x2, 0x4, 0x8, 0x10 on consecutive cycles.
- Full with simultaneous push/pop: queue at count=DEPTH, wb_hold=0, in_valid=1 -> in_ready=0 that cycle so no push; the next cycle push and pop together leave count=DEPTH-1. Verify no entry is lost across pointer wrap over 3xDEPTH transactions against a reference model.
- Pending query: queue addr=7 with wb_hold=1 -> query_pending(7)=1 and query_pending(8)=0. Release -> query_pending(7) stays 1 through the WriteEnable cycle, then 0.
- Async reset mid-drain: with 3 entries queued, assert reset between edges -> WriteEnable=0 and count=0 immediately; after release, no stale writes appear.
